// File: rtl/stochastic_neuron_pkg.sv
// -----------------------------------------------------------------------------
// stochastic_neuron_pkg
// Shared constants for the stochastic neuron datapath:
//   - operand and probability widths, input count, fixed-point fraction bits
//   - saturation limits (+INF / -INF) used by the accumulation chain
//   - piecewise-linear sigmoid breakpoints and offsets
//   - LFSR tap mask and the one-step LFSR helper
// -----------------------------------------------------------------------------
package stochastic_neuron_pkg;

   localparam int BITLENGTH         = 12;
   localparam int SIGMOID_BITLENGTH = 8;
   localparam int INPUT_DIM         = 15;
   localparam int FRAC_BITS         = 4;

   localparam logic signed [BITLENGTH-1:0] INF     = 12'sh7FF;
   localparam logic signed [BITLENGTH-1:0] NEG_INF = -INF;

   // Sigmoid segments on X = |sum|. The first breakpoint is 1.0 in the
   // sum's fixed-point format.
   localparam int SIG_BP0  = 1 << FRAC_BITS;
   localparam int SIG_BP1  = 38;
   localparam int SIG_BP2  = 80;
   localparam int SIG_OFF0 = 128;
   localparam int SIG_OFF1 = 160;
   localparam int SIG_OFF2 = 216;
   localparam int SIG_ONE  = 256;

   // Fibonacci taps on bits 7,5,4,3 (maximal length, period 255).
   localparam logic [SIGMOID_BITLENGTH-1:0] LFSR_TAPS     = 8'hB8;
   localparam logic [SIGMOID_BITLENGTH-1:0] LFSR_ZERO_SUB = 8'h01;

   function automatic logic [SIGMOID_BITLENGTH-1:0] lfsr_step(
      input logic [SIGMOID_BITLENGTH-1:0] q
   );
      return {q[SIGMOID_BITLENGTH-2:0], ^(q & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/stochastic_neuron_if.sv
// -----------------------------------------------------------------------------
// stochastic_neuron_if
// Operand / result bundle of one stochastic neuron.
//   in_valid  : operands valid this cycle
//   bias      : signed bias
//   weights   : packed signed weights, weight k at [k*BITLENGTH +: BITLENGTH]
//   inputs    : binary visible units, bit k gates weight k
//   out_valid : result registers valid
//   sum       : saturated pre-activation
//   prob      : sigmoid(sum) scaled to 0..255
//   sample    : Bernoulli sample, prob > rnd
// master = layer sequencer, slave = neuron.
// -----------------------------------------------------------------------------
interface stochastic_neuron_if import stochastic_neuron_pkg::*; ();

   logic                               in_valid;
   logic signed [BITLENGTH-1:0]        bias;
   logic [INPUT_DIM*BITLENGTH-1:0]     weights;
   logic [INPUT_DIM-1:0]               inputs;
   logic                               out_valid;
   logic signed [BITLENGTH-1:0]        sum;
   logic [SIGMOID_BITLENGTH-1:0]       prob;
   logic                               sample;

   modport master (
      output in_valid, bias, weights, inputs,
      input  out_valid, sum, prob, sample
   );

   modport slave (
      input  in_valid, bias, weights, inputs,
      output out_valid, sum, prob, sample
   );

endinterface

// File: rtl/ap_adder.sv
// -----------------------------------------------------------------------------
// ap_adder
// Combinational saturating adder: y = clamp(a + b, -INF, +INF).
//   a_i : signed operand
//   b_i : signed operand
//   y_o : saturated signed sum
// -----------------------------------------------------------------------------
module ap_adder import stochastic_neuron_pkg::*; (
   input  logic signed [BITLENGTH-1:0] a_i,
   input  logic signed [BITLENGTH-1:0] b_i,
   output logic signed [BITLENGTH-1:0] y_o
);

   localparam logic signed [BITLENGTH:0] POS_LIM = (BITLENGTH+1)'(INF);
   localparam logic signed [BITLENGTH:0] NEG_LIM = (BITLENGTH+1)'(NEG_INF);

   logic signed [BITLENGTH:0] s;

   always_comb begin
      // One guard bit holds any sum of two in-range operands exactly.
      s = (BITLENGTH+1)'(a_i) + (BITLENGTH+1)'(b_i);
      if (s > POS_LIM) begin
         y_o = INF;
      end else if (s < NEG_LIM) begin
         y_o = NEG_INF;
      end else begin
         y_o = s[BITLENGTH-1:0];
      end
   end

endmodule

// File: rtl/random_generator.sv
// -----------------------------------------------------------------------------
// random_generator
// 8-bit Fibonacci LFSR supplying the Bernoulli threshold.
//   clock  : rising-edge clock
//   reset  : synchronous active-high, loads seed_i (0 is replaced by 8'h01)
//   seed_i : LFSR seed
//   step_i : advance one state this cycle
//   rnd_o  : current LFSR state
// -----------------------------------------------------------------------------
module random_generator import stochastic_neuron_pkg::*; (
   input  logic                         clock,
   input  logic                         reset,
   input  logic [SIGMOID_BITLENGTH-1:0] seed_i,
   input  logic                         step_i,
   output logic [SIGMOID_BITLENGTH-1:0] rnd_o
);

   logic [SIGMOID_BITLENGTH-1:0] lfsr_q, lfsr_d;

   always_comb begin
      lfsr_d = lfsr_q;
      if (step_i) begin
         lfsr_d = lfsr_step(lfsr_q);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         // The all-zero state is a lock-up state of the LFSR.
         lfsr_q <= (seed_i == '0) ? LFSR_ZERO_SUB : seed_i;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   assign rnd_o = lfsr_q;

endmodule

// File: rtl/sigmoid.sv
// -----------------------------------------------------------------------------
// sigmoid
// Combinational 8-bit piecewise-linear sigmoid of a signed fixed-point sum.
//   sum_i  : signed pre-activation
//   prob_o : probability scaled to 0..255
// -----------------------------------------------------------------------------
module sigmoid import stochastic_neuron_pkg::*; (
   input  logic signed [BITLENGTH-1:0]  sum_i,
   output logic [SIGMOID_BITLENGTH-1:0] prob_o
);

   logic signed [BITLENGTH:0]   s_ext;
   logic [BITLENGTH:0]          x;
   logic [SIGMOID_BITLENGTH:0]  f;
   logic [SIGMOID_BITLENGTH:0]  neg_f;

   always_comb begin
      // Magnitude is taken one bit wider so that -2048 maps to 2048.
      s_ext = (BITLENGTH+1)'(sum_i);
      x     = (s_ext < 0) ? unsigned'(-s_ext) : unsigned'(s_ext);

      if (int'(x) < SIG_BP0) begin
         f = (SIGMOID_BITLENGTH+1)'(SIG_OFF0 + 4 * int'(x));
      end else if (int'(x) < SIG_BP1) begin
         f = (SIGMOID_BITLENGTH+1)'(SIG_OFF1 + 2 * int'(x));
      end else if (int'(x) < SIG_BP2) begin
         f = (SIGMOID_BITLENGTH+1)'(SIG_OFF2 + (int'(x) >> 1));
      end else begin
         f = (SIGMOID_BITLENGTH+1)'(SIG_ONE);
      end

      // Negative side mirrors around 128; f >= 128 keeps this in 0..128.
      neg_f = (SIGMOID_BITLENGTH+1)'(SIG_ONE) - f;

      if (!sum_i[BITLENGTH-1]) begin
         prob_o = f[SIGMOID_BITLENGTH] ? '1 : f[SIGMOID_BITLENGTH-1:0];
      end else begin
         prob_o = neg_f[SIGMOID_BITLENGTH-1:0];
      end
   end

endmodule

// File: rtl/stochastic_neuron.sv
// -----------------------------------------------------------------------------
// stochastic_neuron
// Stochastic binary neuron: saturating gated weighted sum, piecewise-linear
// sigmoid, Bernoulli sample against an LFSR. One result per in_valid, latency 1.
//   clock : rising-edge clock
//   reset : synchronous active-high; clears outputs, reloads the LFSR seed
//   seed  : LFSR seed, sampled during reset
//   nif   : operand/result bundle (slave side), see stochastic_neuron_if
// -----------------------------------------------------------------------------
module stochastic_neuron import stochastic_neuron_pkg::*; (
   input  logic                         clock,
   input  logic                         reset,
   input  logic [SIGMOID_BITLENGTH-1:0] seed,
   stochastic_neuron_if.slave           nif
);

   logic signed [BITLENGTH-1:0]  acc [INPUT_DIM+1];
   logic [SIGMOID_BITLENGTH-1:0] prob_w;
   logic [SIGMOID_BITLENGTH-1:0] rnd_w;

   logic                         out_valid_q, out_valid_d;
   logic signed [BITLENGTH-1:0]  sum_q, sum_d;
   logic [SIGMOID_BITLENGTH-1:0] prob_q, prob_d;
   logic                         sample_q, sample_d;

   assign acc[0] = nif.bias;

   // Saturation happens at every link, so the chain order is significant.
   for (genvar k = 0; k < INPUT_DIM; k++) begin : g_chain
      logic signed [BITLENGTH-1:0] term;
      assign term = nif.inputs[k] ? nif.weights[k*BITLENGTH +: BITLENGTH] : '0;
      ap_adder u_add (
         .a_i (acc[k]),
         .b_i (term),
         .y_o (acc[k+1])
      );
   end

   sigmoid u_sig (
      .sum_i  (acc[INPUT_DIM]),
      .prob_o (prob_w)
   );

   // The sample uses the state before this cycle's step.
   random_generator u_rng (
      .clock  (clock),
      .reset  (reset),
      .seed_i (seed),
      .step_i (nif.in_valid),
      .rnd_o  (rnd_w)
   );

   always_comb begin
      out_valid_d = nif.in_valid;
      sum_d       = sum_q;
      prob_d      = prob_q;
      sample_d    = sample_q;
      if (nif.in_valid) begin
         sum_d    = acc[INPUT_DIM];
         prob_d   = prob_w;
         sample_d = (prob_w > rnd_w);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         out_valid_q <= 1'b0;
         sum_q       <= '0;
         prob_q      <= '0;
         sample_q    <= 1'b0;
      end else begin
         out_valid_q <= out_valid_d;
         sum_q       <= sum_d;
         prob_q      <= prob_d;
         sample_q    <= sample_d;
      end
   end

   assign nif.out_valid = out_valid_q;
   assign nif.sum       = sum_q;
   assign nif.prob      = prob_q;
   assign nif.sample    = sample_q;

endmodule

// File: tb/tb_stochastic_neuron.sv
// -----------------------------------------------------------------------------
// tb_stochastic_neuron
// Self-checking bench for stochastic_neuron: directed steps plus randomized
// operands compared against an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_stochastic_neuron;
   import stochastic_neuron_pkg::*;

   logic       clock = 1'b0;
   logic       reset;
   logic [7:0] seed;

   stochastic_neuron_if nif ();

   stochastic_neuron dut (
      .clock (clock),
      .reset (reset),
      .seed  (seed),
      .nif   (nif)
   );

   always #5 clock = ~clock;

   int n_checks = 0;
   int n_fail   = 0;
   int wv [INPUT_DIM];
   int m_rnd;
   int m_last_sum;
   int m_last_prob;
   int m_last_sample;

   task automatic chk(input string tag, input logic signed [31:0] obs,
                      input logic signed [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Reference: bias then every weight in order, clamped after each addition.
   function automatic int m_sum(input int b, input int inb);
      int acc = b;
      for (int k = 0; k < INPUT_DIM; k++) begin
         acc = acc + (inb[k] ? wv[k] : 0);
         if (acc > 2047)  acc = 2047;
         if (acc < -2047) acc = -2047;
      end
      return acc;
   endfunction

   function automatic int m_prob(input int s);
      int x = (s < 0) ? -s : s;
      int f;
      if (x < 16)      f = 128 + 4 * x;
      else if (x < 38) f = 160 + 2 * x;
      else if (x < 80) f = 216 + x / 2;
      else             f = 256;
      if (s >= 0) return (f > 255) ? 255 : f;
      return 256 - f;
   endfunction

   function automatic int m_lfsr_next(input int q);
      int fb = q[7] ^ q[5] ^ q[4] ^ q[3];
      return ((q << 1) & 255) | fb;
   endfunction

   function automatic int rand_val();
      if ($urandom_range(0, 3) == 0) return int'($urandom_range(0, 4095)) - 2048;
      return int'($urandom_range(0, 80)) - 40;
   endfunction

   task automatic clear_w();
      for (int k = 0; k < INPUT_DIM; k++) wv[k] = 0;
   endtask

   task automatic do_reset(input int s, input bit with_valid);
      seed         = 8'(s);
      reset        = 1'b1;
      nif.in_valid = with_valid;
      @(posedge clock);
      #1;
      reset        = 1'b0;
      nif.in_valid = 1'b0;
      m_rnd        = (s == 0) ? 1 : s;
      m_last_sum    = 0;
      m_last_prob   = 0;
      m_last_sample = 0;
      chk("rst_out_valid", nif.out_valid, 0);
      chk("rst_sum", nif.sum, 0);
      chk("rst_prob", nif.prob, 0);
      chk("rst_sample", nif.sample, 0);
   endtask

   task automatic step(input string tag, input int b, input int inb);
      nif.bias   = 12'(b);
      for (int k = 0; k < INPUT_DIM; k++)
         nif.weights[k*BITLENGTH +: BITLENGTH] = 12'(wv[k]);
      nif.inputs   = 15'(inb);
      nif.in_valid = 1'b1;
      @(posedge clock);
      #1;
      m_last_sum    = m_sum(b, inb);
      m_last_prob   = m_prob(m_last_sum);
      m_last_sample = (m_last_prob > m_rnd) ? 1 : 0;
      chk({tag, "_valid"}, nif.out_valid, 1);
      chk({tag, "_sum"}, nif.sum, m_last_sum);
      chk({tag, "_prob"}, nif.prob, m_last_prob);
      chk({tag, "_sample"}, nif.sample, m_last_sample);
      m_rnd = m_lfsr_next(m_rnd);
   endtask

   task automatic idle(input string tag);
      nif.in_valid = 1'b0;
      @(posedge clock);
      #1;
      chk({tag, "_valid"}, nif.out_valid, 0);
      chk({tag, "_sum_hold"}, nif.sum, m_last_sum);
      chk({tag, "_prob_hold"}, nif.prob, m_last_prob);
      chk({tag, "_sample_hold"}, nif.sample, m_last_sample);
   endtask

   task automatic random_steps(input int n, input bit gaps);
      for (int i = 0; i < n; i++) begin
         for (int k = 0; k < INPUT_DIM; k++) wv[k] = rand_val();
         step("rand", rand_val(), int'($urandom_range(0, 32767)));
         if (gaps && $urandom_range(0, 7) == 0) idle("rand_gap");
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int lfsr_sums [5] = '{-78, -76, -72, -64, -46};
      reset        = 1'b1;
      seed         = 8'h01;
      nif.in_valid = 1'b0;
      nif.bias     = '0;
      nif.weights  = '0;
      nif.inputs   = '0;
      clear_w();

      // Reset state, then sigmoid points with back-to-back operands.
      do_reset(1, 0);
      step("zero", 0, 0);
      step("p16", 16, 0);
      step("m16", -16, 0);
      step("p40", 40, 0);
      step("p2047", 2047, 0);
      idle("idle1");

      do_reset(1, 0);
      step("m2047", -2047, 0);

      // Seed 0: probabilities equal to the expected rnd give sample 0.
      do_reset(0, 0);
      foreach (lfsr_sums[i]) step("lfsr_seq", lfsr_sums[i], 0);
      idle("idle2");

      // Saturation, ordering and gating.
      clear_w();
      wv[0] = 32;
      step("sat_pos", 2032, 1);
      wv[0] = -32;
      step("sat_neg", -2032, 1);
      wv[0] = 32;
      wv[1] = -16;
      step("order", 2032, 3);
      step("gate", 2032, 2);
      step("all_off", 2032, 0);

      // Reset arriving with in_valid high discards the operand.
      step("pre_rst", 100, 0);
      do_reset(8'h40, 1);
      clear_w();
      step("post_rst", -16, 0);
      step("post_rst2", -15, 0);

      // Full LFSR period: after 255 steps the threshold is back to 01.
      do_reset(1, 0);
      random_steps(255, 0);
      clear_w();
      step("wrap", -78, 0);
      step("wrap2", -76, 0);

      // Randomized mix with idle gaps.
      do_reset(int'($urandom_range(0, 255)), 0);
      random_steps(300, 1);
      idle("idle_end");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
